// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable response latency.
// Define DMEM_RESPONDER_CHECK_EN to flag misaligned or out-of-range requests.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h80000000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT_M1 =
      (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic accept;
   logic enter_rsp;
   logic wr_en;

   logic [31:0] mem [DEPTH];
   logic [31:0] offset;
   logic [31:0] merged;
   logic [ADDR_WIDTH-1:0] idx_in;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic err_in;
   logic err_q;

   assign offset = req_addr - BASE_ADDR;
   assign idx_in = offset[ADDR_WIDTH+1:2];

`ifdef DMEM_RESPONDER_CHECK_EN
   assign err_in = (offset[1:0] != 2'b00) ||
                   ({1'b0, offset} >= (33'd4 << ADDR_WIDTH));
`else
   // Low address bits and aliasing bits are deliberately ignored here.
   logic unused_bits;
   assign unused_bits = ^{offset[1:0], offset[31:ADDR_WIDTH+2]};
   assign err_in = 1'b0;
`endif

   assign wr_en = accept && !err_in;

   // Next-state logic for the IDLE/WAIT/RESP handshake sequencer.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      accept    = 1'b0;
      enter_rsp = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  state_nx  = RESP;
                  enter_rsp = 1'b1;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = 4'd0;
               end
            end
         end
         WAIT: begin
            cnt_nx = cnt + 4'd1;
            if (cnt == LAT_M1) begin
               state_nx  = RESP;
               enter_rsp = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, wait counter and the request fields kept for the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            idx_q <= idx_in;
            err_q <= err_in;
         end
      end
   end

   // Word seen by a zero-latency response: array word with this store merged.
   always_comb begin
      merged = mem[idx_in];
      for (int i = 0; i < 4; i++) begin
         if (req_wstrb[i]) begin
            merged[8*i +: 8] = req_wdata[8*i +: 8];
         end
      end
   end

   // Byte-masked store into the array; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (req_wstrb[i]) begin
               mem[idx_in][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Registered handshake outputs and response payload captured on RESP entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         req_ready <= (state_nx == IDLE);
         rsp_valid <= (state_nx == RESP);
         if (enter_rsp) begin
            if (state == IDLE) begin
               rsp_rdata <= err_in ? 32'd0 : merged;
               rsp_err   <= err_in;
            end else begin
               rsp_rdata <= err_q ? 32'd0 : mem[idx_q];
               rsp_err   <= err_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vectors, corner sequences and random traffic
// against a word-array model; two instances cover LATENCY 2 and 0.
module tb_dmem_responder;

   localparam int unsigned AW = 12;
   localparam logic [31:0] BASE = 32'h80000000;
   localparam logic [31:0] SPAN = 32'd4 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic req_valid = 1'b0;
   logic rsp_ready = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0] req_wstrb = '0;

   logic a_ready, a_valid, a_err;
   logic [31:0] a_rdata;
   logic b_ready, b_valid, b_err;
   logic [31:0] b_rdata;
   logic ready_m, valid_m, err_m;
   logic [31:0] rdata_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .LATENCY(2)
   ) u_lat2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & ~sel), .req_ready(a_ready),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb),
      .rsp_valid(a_valid), .rsp_ready(rsp_ready & ~sel),
      .rsp_rdata(a_rdata), .rsp_err(a_err)
   );

   dmem_responder #(
      .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .LATENCY(0)
   ) u_lat0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & sel), .req_ready(b_ready),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb),
      .rsp_valid(b_valid), .rsp_ready(rsp_ready & sel),
      .rsp_rdata(b_rdata), .rsp_err(b_err)
   );

   assign ready_m = sel ? b_ready : a_ready;
   assign valid_m = sel ? b_valid : a_valid;
   assign err_m   = sel ? b_err   : a_err;
   assign rdata_m = sel ? b_rdata : a_rdata;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
   } vec_t;

   vec_t vt [7];
   logic [31:0] model [4096];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   // Present a request and return just after the edge that accepts it.
   task automatic start_req(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = wd;
      req_wstrb = ws;
      n = 0;
      while (!ready_m && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready_m) begin
         errors++;
         $display("FAIL accept_timeout actual 0 required 1");
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
   endtask

   task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd,
                      output logic er, output int lat);
      start_req(a, wd, ws);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!valid_m && lat < 20);
      rd = rdata_m;
      er = err_m;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // Reference: word array updated lane by lane, with optional range check.
   task automatic model_txn(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, output logic [31:0] rd,
                            output logic er);
      logic [31:0] off;
      int w;
      off = a - BASE;
`ifdef DMEM_RESPONDER_CHECK_EN
      er = (a % 4 != 0) || (off >= SPAN);
`else
      er = 1'b0;
`endif
      w = int'((off >> 2) % 4096);
      if (!er) begin
         for (int l = 0; l < 4; l++) begin
            if (ws[l]) model[w][8*l +: 8] = wd[8*l +: 8];
         end
      end
      rd = er ? 32'd0 : model[w];
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, hold, a, wd, erd;
      logic er, eer;
      logic [3:0] ws;
      int lat, n, seen;

      vt[0] = '{32'h80000010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
      vt[1] = '{32'h80000010, 32'h00000000, 4'h0, 32'hDEADBEEF};
      vt[2] = '{32'h80000020, 32'h11223344, 4'hF, 32'h11223344};
      vt[3] = '{32'h80000020, 32'hAABBCCDD, 4'h5, 32'h11BB33DD};
      vt[4] = '{32'h80000020, 32'h00000000, 4'h0, 32'h11BB33DD};
      vt[5] = '{32'h80000010, 32'h99000000, 4'h8, 32'h99ADBEEF};
      vt[6] = '{32'h80000010, 32'h55555555, 4'h0, 32'h99ADBEEF};

      // reset held three cycles
      repeat (2) @(negedge clk);
      check("rst_flags", {29'd0, a_ready, a_valid, a_err}, 32'd0);
      check("rst_rdata", a_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rdy_at_release", {31'd0, a_ready}, 32'd0);
      @(negedge clk);
      check("rdy_after_rst", {31'd0, a_ready}, 32'd1);

      // directed vectors at LATENCY 2
      foreach (vt[i]) begin
         txn(vt[i].addr, vt[i].wdata, vt[i].wstrb, rd, er, lat);
         check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
         check($sformatf("vec%0d_err", i), {31'd0, er}, 32'd0);
         check($sformatf("vec%0d_lat", i), lat, 32'd3);
      end

      // backpressure with a second request held pending
      start_req(32'h80000020, 32'h0, 4'h0);
      req_valid = 1'b1;
      req_addr  = 32'h80000010;
      req_wstrb = 4'hF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!valid_m && n < 20);
      hold = rdata_m;
      check("bp_data", hold, 32'h11BB33DD);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", {31'd0, valid_m}, 32'd1);
         check("bp_rdata", rdata_m, hold);
         check("bp_ready", {31'd0, ready_m}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("fire_ready", {31'd0, ready_m}, 32'd1);
      check("fire_valid", {31'd0, valid_m}, 32'd0);
      txn(32'h80000010, 32'h0, 4'h0, rd, er, lat);
      check("bp_no_store", rd, 32'h99ADBEEF);

      // LATENCY 0, wrap and error handling
      @(negedge clk);
      sel = 1'b1;
      txn(32'h80000000, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      check("l0_store_rdata", rd, 32'hA5A5A5A5);
      check("l0_lat", lat, 32'd1);
      txn(32'h80000010, 32'h12345678, 4'hF, rd, er, lat);
      check("l0_store2", rd, 32'h12345678);
      txn(32'h80004010, 32'h0, 4'h0, rd, er, lat);
`ifdef DMEM_RESPONDER_CHECK_EN
      check("wrap_rdata", rd, 32'd0);
      check("wrap_err", {31'd0, er}, 32'd1);
`else
      check("wrap_rdata", rd, 32'h12345678);
      check("wrap_err", {31'd0, er}, 32'd0);
`endif
      check("wrap_lat", lat, 32'd1);
      txn(32'h80000002, 32'h0, 4'h0, rd, er, lat);
`ifdef DMEM_RESPONDER_CHECK_EN
      check("misal_rdata", rd, 32'd0);
      check("misal_err", {31'd0, er}, 32'd1);
`else
      check("misal_rdata", rd, 32'hA5A5A5A5);
      check("misal_err", {31'd0, er}, 32'd0);
`endif
      txn(32'h80004010, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      txn(32'h80000010, 32'h0, 4'h0, rd, er, lat);
`ifdef DMEM_RESPONDER_CHECK_EN
      check("err_store_blocked", rd, 32'h12345678);
`else
      check("wrap_store", rd, 32'hFFFFFFFF);
`endif
      @(negedge clk);
      sel = 1'b0;

      // reset while waiting
      start_req(32'h80000040, 32'h0000CAFE, 4'hF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         seen += int'(a_valid);
      end
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen += int'(a_valid);
      end
      check("rst_wait_novalid", seen, 32'd0);
      txn(32'h80000040, 32'h0, 4'h0, rd, er, lat);
      check("rst_wait_kept", rd, 32'h0000CAFE);

      // random traffic against the model
      for (int i = 0; i < 16; i++) begin
         a  = BASE + 32'(i * 4);
         wd = $urandom;
         model_txn(a, wd, 4'hF, erd, eer);
         txn(a, wd, 4'hF, rd, er, lat);
         check("seed", rd, erd);
      end
      for (int i = 0; i < 120; i++) begin
         a = BASE + 32'($urandom_range(0, 15) * 4);
         n = $urandom_range(0, 3);
         if (n == 0) a += 32'($urandom_range(1, 3));
         else if (n == 1) a += SPAN * 32'($urandom_range(1, 3));
         else if ($urandom_range(0, 3) == 0) a -= SPAN;
         wd = $urandom;
         ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         model_txn(a, wd, ws, erd, eer);
         txn(a, wd, ws, rd, er, lat);
         check($sformatf("rnd%0d_rdata@%h", i, a), rd, erd);
         check($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, eer});
         check($sformatf("rnd%0d_lat", i), lat, 32'd3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. Accepts one load or store request at a time from a requester over a valid/ready channel, applies byte-masked writes to an internal word-addressed array, and returns read data on a separate valid/ready response channel after a programmable number of wait cycles. It lets the core, or a future multi-cycle load/store unit, be exercised against realistic memory latency instead of a zero-wait array.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; array depth = 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, 32'h80000000: byte address of word 0.
- `LATENCY`, 2: wait cycles between request acceptance and response valid; legal range 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  requester has a request.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, byte lanes aligned to the word.
- `req_wstrb`  in  4  byte write enables; 4'b0000 means read.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  word at the request address.
- `rsp_err`  out  1  request was rejected (see Configuration).

## Operation
- States: IDLE, WAIT, RESP. Wait counter is 4 bits.
- IDLE: `req_ready`=1. A request is accepted on the edge where `req_valid && req_ready`. On that edge, address, strobes and error flag are latched, and any write is committed to the array (byte lane i is written only when `req_wstrb[i]`=1). Next state is WAIT with counter=0 when LATENCY≥1, or RESP when LATENCY=0.
- WAIT: `req_ready`=0. The counter increments each edge. On the edge where counter==LATENCY-1, state moves to RESP.
- Entry to RESP: `rsp_rdata` is loaded from the array at the latched word index, after any write from this request, so a store returns the merged word. `rsp_rdata` and `rsp_err` stay stable while `rsp_valid`=1.
- RESP: `rsp_valid`=1 and `req_ready`=0. On the edge where `rsp_ready`=1, state returns to IDLE and `rsp_valid` clears.
- Word index = (req_addr - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits.
- Array contents are not cleared by reset.
- Reset, including mid-transaction: state goes to IDLE. `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. A write already committed at acceptance stays committed; an in-flight response is dropped.

## Timing
- `req_ready`, `rsp_valid`, `rsp_rdata` and `rsp_err` are registered outputs. `req_ready` rises on the first edge after `rst` deasserts.
- Accept at edge E. `rsp_valid` is first high in the cycle after edge E+LATENCY, where E+0 means E itself.
- Response fire at edge F. `req_ready` is high in the cycle after F.
- Minimum spacing of back-to-back transactions: LATENCY+2 cycles.
- `req_*` inputs are sampled only on the accept edge and may change freely afterwards.
- `rsp_ready` held high continuously: each response lasts exactly one cycle.

## Configuration
- `DMEM_RESPONDER_CHECK_EN` defined:
  - A request is an error when `req_addr[1:0]`≠0, or when req_addr lies outside [BASE_ADDR, BASE_ADDR + 4·2^ADDR_WIDTH).
  - An error request suppresses the write, returns `rsp_rdata`=0 and `rsp_err`=1, and keeps the same latency.
- Not defined:
  - `req_addr[1:0]` is ignored and the index wraps modulo the array depth.
  - `rsp_err` is tied to 0.

## Test plan
- Reset then idle: hold `rst` 3 cycles -> all outputs 0; `req_ready`=1 one cycle after release.
- Full store then load with LATENCY=2: store 32'hDEADBEEF, wstrb 4'hF at 0x80000010, then load the same address -> each `rsp_valid` is first high 3 cycles after its accept cycle; load returns 32'hDEADBEEF.
- Partial store: word holds 32'h11223344; store wdata 32'hAABBCCDD, wstrb 4'b0101 -> store response and a later load both return 32'h11BB33DD.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0 while `req_valid` is held high; no second accept occurs.
- LATENCY=0 and wrap: `rsp_valid` is high in the cycle after accept. With the macro undefined and ADDR_WIDTH=12, a load of 0x80004010 returns word 4. With the macro defined, the same load and a load of 0x80000002 both give `rsp_err`=1 and `rsp_rdata`=0.
- Reset in WAIT: assert `rst` one cycle after accepting a store of 32'h0000CAFE -> `rsp_valid` never rises; after release, a load of that address returns 32'h0000CAFE.
